// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared parameters and types for the AES-128 round scheduler
//
// Purpose : default widths/limits, scheduler state encoding and the
//           round-index type shared by the scheduler and its key store.
// Ports   : none (package).
package aes_pkg;

  localparam int KEY_LEN_DEFAULT       = 128;
  localparam int NUMS_OF_ROUND_DEFAULT = 10;
  localparam int KEXP_TIMEOUT_DEFAULT  = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_READY = 3'd2,
    ST_ROUND = 3'd3,
    ST_OUT   = 3'd4
  } sched_state_e;

  // Round 0 selects the whitening key rk0; 1..NUMS_OF_ROUND select expanded keys.
  typedef logic [3:0] round_idx_t;

endpackage

// File: rtl/aes_rkey_store.sv
// rtl/aes_rkey_store.sv - round-key register file with rk0 and indexed read
//
// Purpose : holds the whitening key rk0 and the NUMS_OF_ROUND expanded keys.
// Ports   : i_clk/i_rst_n  clock, async active-low reset
//           i_rk0_we/i_rk0 write port for rk0 (on key acceptance)
//           i_load_en/i_keys bulk write of all expanded keys (slice i = key i+1)
//           i_idx          read index (0 = rk0)
//           o_rk0          rk0 direct
//           o_rkey         combinational key selected by i_idx
module aes_rkey_store
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = KEY_LEN_DEFAULT,
  parameter int NUMS_OF_ROUND = NUMS_OF_ROUND_DEFAULT
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_rk0_we,
  input  logic [KEY_LEN-1:0]               i_rk0,
  input  logic                             i_load_en,
  input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] i_keys,
  input  round_idx_t                       i_idx,
  output logic [KEY_LEN-1:0]               o_rk0,
  output logic [KEY_LEN-1:0]               o_rkey
);

  logic [KEY_LEN-1:0]               r_rk0;
  logic [NUMS_OF_ROUND*KEY_LEN-1:0] r_rk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rk0 <= '0;
      r_rk  <= '0;
    end else begin
      if (i_rk0_we) begin
        r_rk0 <= i_rk0;
      end
      if (i_load_en) begin
        r_rk <= i_keys;
      end
    end
  end

  assign o_rk0 = r_rk0;

  // Indices beyond NUMS_OF_ROUND read as zero.
  always_comb begin
    o_rkey = '0;
    if (i_idx == round_idx_t'(0)) begin
      o_rkey = r_rk0;
    end
    for (int i = 0; i < NUMS_OF_ROUND; i++) begin
      if (i_idx == round_idx_t'(i + 1)) begin
        o_rkey = r_rk[i*KEY_LEN +: KEY_LEN];
      end
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// rtl/aes_round_scheduler.sv - AES-128 encrypt controller: key expansion capture and round sequencing
//
// Purpose : accepts a key, starts the external key-expansion unit and captures
//           its round keys; then accepts plaintext blocks and walks one
//           iterative round datapath through rounds 1..NUMS_OF_ROUND,
//           presenting the ciphertext on a valid/ready output.
// Ports   : clk, reset (async active-low)
//           key_in/key_valid/key_ready          host key handshake
//           ke_key/ke_valid_in                  start of expansion unit
//           ke_valid_out/ke_key_expan           expansion results
//           blk_in/blk_valid/blk_ready          plaintext handshake
//           round_state/round_key/round_idx/round_en/final_round  round datapath operands
//           round_result                        round datapath result (combinational)
//           blk_out/blk_out_valid/blk_out_ready ciphertext handshake
//           key_loaded, kexp_err                status
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = KEY_LEN_DEFAULT,
  parameter int NUMS_OF_ROUND = NUMS_OF_ROUND_DEFAULT,
  parameter int KEXP_TIMEOUT  = KEXP_TIMEOUT_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [KEY_LEN-1:0]               key_in,
  input  logic                             key_valid,
  output logic                             key_ready,
  output logic [KEY_LEN-1:0]               ke_key,
  output logic                             ke_valid_in,
  input  logic [NUMS_OF_ROUND-1:0]         ke_valid_out,
  input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] ke_key_expan,
  input  logic [KEY_LEN-1:0]               blk_in,
  input  logic                             blk_valid,
  output logic                             blk_ready,
  output logic [KEY_LEN-1:0]               round_state,
  output logic [KEY_LEN-1:0]               round_key,
  output logic [3:0]                       round_idx,
  output logic                             round_en,
  output logic                             final_round,
  input  logic [KEY_LEN-1:0]               round_result,
  output logic [KEY_LEN-1:0]               blk_out,
  output logic                             blk_out_valid,
  input  logic                             blk_out_ready,
  output logic                             key_loaded,
  output logic                             kexp_err
);

  localparam int TCNT_W = $clog2(KEXP_TIMEOUT + 1);

  sched_state_e       r_fsm;
  sched_state_e       w_nxt_fsm;
  logic [KEY_LEN-1:0] r_data;
  logic [KEY_LEN-1:0] w_nxt_data;
  round_idx_t         r_rcnt;
  round_idx_t         w_nxt_rcnt;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [TCNT_W-1:0]  w_nxt_tcnt;

  logic [KEY_LEN-1:0] r_ke_key;
  logic               r_ke_valid_in;
  logic               r_key_loaded;
  logic               r_kexp_err;
  logic [KEY_LEN-1:0] r_round_state;
  logic [KEY_LEN-1:0] r_round_key;
  round_idx_t         r_round_idx;
  logic               r_round_en;
  logic               r_final_round;
  logic [KEY_LEN-1:0] r_blk_out;
  logic               r_blk_out_valid;

  logic               w_key_acc;
  logic               w_blk_acc;
  logic               w_kexp_done;
  logic               w_kexp_to;
  logic               w_out_acc;
  logic               w_nxt_round;
  logic               w_nxt_out;
  logic [KEY_LEN-1:0] w_rk0;
  logic [KEY_LEN-1:0] w_rk_rd;

  // Only the last stage's valid marks the expansion as complete.
  logic w_unused_stage_valid;
  assign w_unused_stage_valid = ^ke_valid_out[NUMS_OF_ROUND-2:0];

  // Ready signals are the only combinational outputs; gating with reset keeps
  // every output at 0 while reset is held low.
  assign key_ready = reset & ((r_fsm == ST_IDLE) | (r_fsm == ST_READY));
  assign blk_ready = reset & (r_fsm == ST_READY) & ~key_valid;

  assign w_key_acc   = key_valid & key_ready;
  assign w_blk_acc   = blk_valid & blk_ready;
  assign w_kexp_done = (r_fsm == ST_KEXP) & ke_valid_out[NUMS_OF_ROUND-1];
  // Completion in the same cycle as the last allowed count still wins.
  assign w_kexp_to   = (r_fsm == ST_KEXP) & ~ke_valid_out[NUMS_OF_ROUND-1]
                     & (r_tcnt == TCNT_W'(KEXP_TIMEOUT - 1));
  assign w_out_acc   = (r_fsm == ST_OUT) & blk_out_ready;

  always_comb begin
    w_nxt_fsm  = r_fsm;
    w_nxt_data = r_data;
    w_nxt_rcnt = r_rcnt;
    w_nxt_tcnt = r_tcnt;
    unique case (r_fsm)
      ST_IDLE: begin
        if (w_key_acc) begin
          w_nxt_fsm  = ST_KEXP;
          w_nxt_tcnt = '0;
        end
      end
      ST_KEXP: begin
        if (w_kexp_done) begin
          w_nxt_fsm = ST_READY;
        end else if (w_kexp_to) begin
          w_nxt_fsm = ST_IDLE;
        end else begin
          w_nxt_tcnt = r_tcnt + 1'b1;
        end
      end
      ST_READY: begin
        if (w_key_acc) begin
          w_nxt_fsm  = ST_KEXP;
          w_nxt_tcnt = '0;
        end else if (w_blk_acc) begin
          w_nxt_fsm  = ST_ROUND;
          w_nxt_data = blk_in ^ w_rk0;
          w_nxt_rcnt = round_idx_t'(1);
        end
      end
      ST_ROUND: begin
        w_nxt_data = round_result;
        // Counter parks at the last round instead of wrapping.
        if (r_rcnt == round_idx_t'(NUMS_OF_ROUND)) begin
          w_nxt_fsm = ST_OUT;
        end else begin
          w_nxt_rcnt = r_rcnt + 4'd1;
        end
      end
      ST_OUT: begin
        if (w_out_acc) begin
          w_nxt_fsm = ST_READY;
        end
      end
      default: begin
        w_nxt_fsm = ST_IDLE;
      end
    endcase
  end

  assign w_nxt_round = (w_nxt_fsm == ST_ROUND);
  assign w_nxt_out   = (w_nxt_fsm == ST_OUT);

  // Read port indexed by the next round so the registered round_key lines up
  // with round_idx and round_state in the same cycle.
  aes_rkey_store #(
    .KEY_LEN       (KEY_LEN),
    .NUMS_OF_ROUND (NUMS_OF_ROUND)
  ) u_rkey_store (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_rk0_we  (w_key_acc),
    .i_rk0     (key_in),
    .i_load_en (w_kexp_done),
    .i_keys    (ke_key_expan),
    .i_idx     (w_nxt_rcnt),
    .o_rk0     (w_rk0),
    .o_rkey    (w_rk_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm           <= ST_IDLE;
      r_data          <= '0;
      r_rcnt          <= '0;
      r_tcnt          <= '0;
      r_ke_key        <= '0;
      r_ke_valid_in   <= 1'b0;
      r_key_loaded    <= 1'b0;
      r_kexp_err      <= 1'b0;
      r_round_state   <= '0;
      r_round_key     <= '0;
      r_round_idx     <= '0;
      r_round_en      <= 1'b0;
      r_final_round   <= 1'b0;
      r_blk_out       <= '0;
      r_blk_out_valid <= 1'b0;
    end else begin
      r_fsm  <= w_nxt_fsm;
      r_data <= w_nxt_data;
      r_rcnt <= w_nxt_rcnt;
      r_tcnt <= w_nxt_tcnt;

      r_ke_valid_in <= w_key_acc;
      if (w_key_acc) begin
        r_ke_key <= key_in;
      end

      if (w_key_acc) begin
        r_key_loaded <= 1'b0;
      end else if (w_kexp_done) begin
        r_key_loaded <= 1'b1;
      end

      if (w_key_acc) begin
        r_kexp_err <= 1'b0;
      end else if (w_kexp_to) begin
        r_kexp_err <= 1'b1;
      end

      r_round_en    <= w_nxt_round;
      r_round_idx   <= w_nxt_round ? w_nxt_rcnt : '0;
      r_round_state <= w_nxt_round ? w_nxt_data : '0;
      r_round_key   <= w_nxt_round ? w_rk_rd : '0;
      r_final_round <= w_nxt_round & (w_nxt_rcnt == round_idx_t'(NUMS_OF_ROUND));

      // In OUT w_nxt_data holds, so blk_out stays stable while stalled.
      r_blk_out_valid <= w_nxt_out;
      r_blk_out       <= w_nxt_out ? w_nxt_data : '0;
    end
  end

  assign ke_key        = r_ke_key;
  assign ke_valid_in   = r_ke_valid_in;
  assign key_loaded    = r_key_loaded;
  assign kexp_err      = r_kexp_err;
  assign round_state   = r_round_state;
  assign round_key     = r_round_key;
  assign round_idx     = r_round_idx;
  assign round_en      = r_round_en;
  assign final_round   = r_final_round;
  assign blk_out       = r_blk_out;
  assign blk_out_valid = r_blk_out_valid;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb/tb_aes_round_scheduler.sv - self-checking bench for aes_round_scheduler
module tb_aes_round_scheduler;
  import aes_pkg::*;

  localparam int KL = KEY_LEN_DEFAULT;
  localparam int NR = NUMS_OF_ROUND_DEFAULT;
  localparam int TO = KEXP_TIMEOUT_DEFAULT;

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [KL-1:0]     key_in;
  logic              key_valid;
  logic              key_ready;
  logic [KL-1:0]     ke_key;
  logic              ke_valid_in;
  logic [NR-1:0]     ke_valid_out;
  logic [NR*KL-1:0]  ke_key_expan;
  logic [KL-1:0]     blk_in;
  logic              blk_valid;
  logic              blk_ready;
  logic [KL-1:0]     round_state;
  logic [KL-1:0]     round_key;
  logic [3:0]        round_idx;
  logic              round_en;
  logic              final_round;
  logic [KL-1:0]     round_result;
  logic [KL-1:0]     blk_out;
  logic              blk_out_valid;
  logic              blk_out_ready;
  logic              key_loaded;
  logic              kexp_err;

  logic              m_en;
  logic [NR-1:0]     r_pipe;
  logic [127:0]      sb[$];
  int                errors = 0;
  int                checks = 0;

  aes_round_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .key_in        (key_in),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .ke_key        (ke_key),
    .ke_valid_in   (ke_valid_in),
    .ke_valid_out  (ke_valid_out),
    .ke_key_expan  (ke_key_expan),
    .blk_in        (blk_in),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .round_state   (round_state),
    .round_key     (round_key),
    .round_idx     (round_idx),
    .round_en      (round_en),
    .final_round   (final_round),
    .round_result  (round_result),
    .blk_out       (blk_out),
    .blk_out_valid (blk_out_valid),
    .blk_out_ready (blk_out_ready),
    .key_loaded    (key_loaded),
    .kexp_err      (kexp_err)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, p;
    inv = 8'h01; p = a;
    for (int i = 1; i < 8; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = s[r + 4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  function automatic logic [NR*KL-1:0] expand_keys(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [NR*KL-1:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 1; j <= NR; j++) o[(j-1)*KL +: KL] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return o;
  endfunction

  assign round_result = aes_round(round_state, round_key, final_round);
  assign ke_key_expan = expand_keys(ke_key);
  assign ke_valid_out = r_pipe;

  // Expansion unit timing: start pulse travels NR stages; disabled by m_en=0.
  always @(posedge clk or negedge reset) begin
    if (!reset) r_pipe <= '0;
    else        r_pipe <= {r_pipe[NR-2:0], ke_valid_in & m_en};
  end

  // ---------------- checking helpers ----------------
  task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key handshake in cycle 0; returns sampled in cycle 1.
  task automatic start_key(input logic [127:0] k);
    key_in = k; key_valid = 1'b1;
    #1;
    check_b("key_ready_offer", key_ready, 1'b1);
    tick();
    key_valid = 1'b0; key_in = '0;
    check_b("ke_valid_in_pulse", ke_valid_in, 1'b1);
    check_w("ke_key", ke_key, k);
    check_b("kexp_err_clear", kexp_err, 1'b0);
    check_b("key_loaded_clear", key_loaded, 1'b0);
  endtask

  // Starting in cycle 1, returns the cycle key_loaded is seen and start-pulse count.
  task automatic wait_loaded(output int t, output int pulses);
    pulses = 0; t = 1;
    while (t < 60) begin
      if (ke_valid_in) pulses++;
      if (key_loaded) break;
      tick(); t++;
    end
  endtask

  task automatic run_block(input logic [127:0] blk, input logic [127:0] key0,
                           input logic [127:0] exp, input int stall,
                           output logic [127:0] rk_last);
    int t;
    logic [127:0] exp_o;
    blk_in = blk; blk_valid = 1'b1; t = 0;
    #1;
    while (!blk_ready && t < 60) begin tick(); t++; end
    check_b("blk_accept", blk_ready, 1'b1);
    sb.push_back(exp);
    tick();
    blk_valid = 1'b0; blk_in = '0;
    check_w("round1_state", round_state, blk ^ key0);
    rk_last = '0;
    for (int r = 1; r <= NR; r++) begin
      check_b("round_en", round_en, 1'b1);
      check_n("round_idx", int'(round_idx), r);
      check_b("final_round", final_round, r == NR);
      if (r == NR) rk_last = round_key;
      tick();
    end
    check_b("out_valid_cycle11", blk_out_valid, 1'b1);
    check_b("out_round_en", round_en, 1'b0);
    check_n("out_round_idx", int'(round_idx), 0);
    key_in = K1 ^ P1; key_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      #1;
      check_b("stall_valid", blk_out_valid, 1'b1);
      if (sb.size() > 0) check_w("stall_blk_out", blk_out, sb[0]);
      check_b("stall_key_ready", key_ready, 1'b0);
      tick();
    end
    key_valid = 1'b0; key_in = '0; blk_out_ready = 1'b1;
    check_n("sb_depth", sb.size(), 1);
    exp_o = (sb.size() > 0) ? sb.pop_front() : 128'h0;
    check_w("blk_out", blk_out, exp_o);
    tick();
    blk_out_ready = 1'b0;
    check_b("out_done", blk_out_valid, 1'b0);
    check_b("back_to_ready", blk_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, p;
    logic [127:0] rk;
    key_in = '0; key_valid = 1'b0; blk_in = '0; blk_valid = 1'b0;
    blk_out_ready = 1'b0; m_en = 1'b0;
    reset = 1'b0;
    repeat (3) tick();

    // Reset state
    check_b("rst_key_ready", key_ready, 1'b0);
    check_b("rst_blk_ready", blk_ready, 1'b0);
    check_b("rst_key_loaded", key_loaded, 1'b0);
    check_b("rst_kexp_err", kexp_err, 1'b0);
    check_b("rst_ke_valid_in", ke_valid_in, 1'b0);
    check_b("rst_round_en", round_en, 1'b0);
    check_b("rst_blk_out_valid", blk_out_valid, 1'b0);
    check_n("rst_round_idx", int'(round_idx), 0);
    check_w("rst_blk_out", blk_out, 128'h0);
    reset = 1'b1;
    tick();
    check_b("idle_key_ready", key_ready, 1'b1);
    blk_valid = 1'b1; #1;
    check_b("idle_blk_ready", blk_ready, 1'b0);
    blk_valid = 1'b0;

    // Expansion timeout
    m_en = 1'b0;
    start_key(K0);
    t = 1;
    while (!kexp_err && t < 60) begin tick(); t++; end
    check_n("kexp_err_cycle", t, TO + 1);
    check_b("to_key_ready", key_ready, 1'b1);
    check_b("to_key_loaded", key_loaded, 1'b0);
    blk_valid = 1'b1; #1;
    check_b("to_blk_ready", blk_ready, 1'b0);
    blk_valid = 1'b0;

    // Key load with FIPS-197 key, then encrypt with 5-cycle output stall
    m_en = 1'b1;
    start_key(K1);
    wait_loaded(t, p);
    check_n("key_loaded_cycle", t, 12);
    check_n("ke_valid_in_pulses", p, 1);
    run_block(P1, K1, C1, 5, rk);
    check_w("rk10", rk, RK10);

    // Key and block offered together in READY: key wins
    key_in = K0; key_valid = 1'b1; blk_in = P0; blk_valid = 1'b1;
    #1;
    check_b("both_key_ready", key_ready, 1'b1);
    check_b("both_blk_ready", blk_ready, 1'b0);
    tick();
    key_valid = 1'b0; key_in = '0;
    check_b("rekey_pulse", ke_valid_in, 1'b1);
    check_b("rekey_no_round", round_en, 1'b0);
    check_b("rekey_loaded_clr", key_loaded, 1'b0);
    wait_loaded(t, p);
    check_n("rekey_loaded_cycle", t, 12);
    run_block(P0, K0, C0, 0, rk);
    run_block(P1, K0 ^ 128'h0, aes_ref_unused_guard(), 0, rk);

    // Reset during ROUND
    blk_in = P0; blk_valid = 1'b1; #1;
    check_b("pre_rst_blk_ready", blk_ready, 1'b1);
    sb.push_back(C0);
    tick();
    blk_valid = 1'b0;
    repeat (3) tick();
    check_b("pre_rst_round_en", round_en, 1'b1);
    reset = 1'b0; #1;
    check_b("mid_rst_round_en", round_en, 1'b0);
    check_n("mid_rst_round_idx", int'(round_idx), 0);
    check_w("mid_rst_round_state", round_state, 128'h0);
    check_w("mid_rst_round_key", round_key, 128'h0);
    check_b("mid_rst_final", final_round, 1'b0);
    check_b("mid_rst_key_loaded", key_loaded, 1'b0);
    check_b("mid_rst_key_ready", key_ready, 1'b0);
    check_b("mid_rst_blk_out_valid", blk_out_valid, 1'b0);
    tick();
    reset = 1'b1;
    sb.delete();
    blk_in = P0; blk_valid = 1'b1; #1;
    check_b("post_rst_key_ready", key_ready, 1'b1);
    check_b("post_rst_blk_ready", blk_ready, 1'b0);
    repeat (4) tick();
    check_b("post_rst_round_en", round_en, 1'b0);
    check_b("post_rst_blk_out_valid", blk_out_valid, 1'b0);
    check_b("post_rst_key_loaded", key_loaded, 1'b0);
    blk_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Expected ciphertext for P1 under K0, derived from the reference round
  // function and key schedule rather than a stored constant.
  function automatic logic [127:0] aes_ref_unused_guard();
    logic [NR*KL-1:0] ks;
    logic [127:0] st;
    ks = expand_keys(K0);
    st = P1 ^ K0;
    for (int r = 1; r <= NR; r++) st = aes_round(st, ks[(r-1)*KL +: KL], r == NR);
    return st;
  endfunction

endmodule
